// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative write-back cache: controller states,
// default geometry and index-width helpers.
package cache_pkg;

  typedef enum logic [2:0] {
    READY,
    WBACK,
    ALLOC,
    FL_SCAN,
    FL_WB
  } state_t;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_SETS   = 4;
  localparam int DEF_WAYS   = 4;
  localparam int DEF_WORDS  = 4;

  // Index width for n entries; a single entry still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU ages (a permutation of 0..WAYS-1, 0 = most recent) plus victim
// selection: lowest invalid way, otherwise the oldest way.
module cache_lru import cache_pkg::*; #(
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS,
  localparam int SET_W = idx_w(SETS),
  localparam int WAY_W = idx_w(WAYS),
  localparam int AGE_W = idx_w(WAYS)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             touch,
  input  logic [SET_W-1:0] set_idx,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [WAYS-1:0]  valid_vec,
  output logic [WAY_W-1:0] victim
);

  logic [AGE_W-1:0] age_reg  [SETS][WAYS];
  logic [AGE_W-1:0] age_next [WAYS];
  logic [AGE_W-1:0] old_age;

  assign old_age = age_reg[set_idx][touch_way];

  // Touched way becomes youngest; only ways younger than it age by one.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
      assign age_next[gi] = (WAY_W'(gi) == touch_way) ? '0 :
                            (age_reg[set_idx][gi] < old_age) ? age_reg[set_idx][gi] + 1'b1 :
                            age_reg[set_idx][gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_reg[s][w] <= AGE_W'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++)
        age_reg[set_idx][w] <= age_next[w];
    end
  end

  always_comb begin
    victim = '0;
    for (int w = 1; w < WAYS; w++)
      if (age_reg[set_idx][w] > age_reg[set_idx][victim]) victim = WAY_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_vec[w]) victim = WAY_W'(w);
  end

endmodule

// File: rtl/cache_assoc.sv
// Set-associative write-back, write-allocate cache with combinational hit path,
// LRU replacement and a line-by-line flush engine.
module cache_assoc import cache_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SETS   = DEF_SETS,
  parameter int WAYS   = DEF_WAYS,
  parameter int WORDS  = DEF_WORDS,
  localparam int OFF_W  = idx_w(WORDS),
  localparam int SET_W  = idx_w(SETS),
  localparam int WAY_W  = idx_w(WAYS),
  localparam int TAG_W  = ADDR_W - OFF_W - SET_W,
  localparam int BLK_W  = 32 * WORDS,
  localparam int LINES  = SETS * WAYS,
  localparam int LINE_W = idx_w(LINES)
) (
  input  logic                    clk,
  input  logic                    proc_reset,
  input  logic                    proc_read,
  input  logic                    proc_write,
  input  logic                    proc_flush,
  input  logic [ADDR_W-1:0]       proc_addr,
  input  logic [31:0]             proc_wdata,
  output logic [31:0]             proc_rdata,
  output logic                    proc_stall,
  output logic                    proc_flush_done,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [BLK_W-1:0]        mem_wdata,
  input  logic [BLK_W-1:0]        mem_rdata,
  input  logic                    mem_ready
);

  state_t state_reg, state_next;

  logic [BLK_W-1:0]  data_reg  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_reg   [SETS][WAYS];
  logic [WAYS-1:0]   valid_reg [SETS];
  logic [WAYS-1:0]   dirty_reg [SETS];
  logic [WAY_W-1:0]  victim_reg;
  logic [LINE_W-1:0] flush_ptr_reg;
  logic              flush_done_reg;

  logic [OFF_W-1:0] off;
  logic [SET_W-1:0] set_idx;
  logic [TAG_W-1:0] tag;
  logic             access;
  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [BLK_W-1:0] hit_block;
  logic [WAY_W-1:0] lru_victim;
  logic             lru_touch;
  logic [WAY_W-1:0] lru_way;
  logic [SET_W-1:0] flush_set;
  logic [WAY_W-1:0] flush_way;
  logic             flush_dirty;
  logic             flush_last;

  assign off     = proc_addr[OFF_W-1:0];
  assign set_idx = proc_addr[OFF_W +: SET_W];
  assign tag     = proc_addr[OFF_W + SET_W +: TAG_W];
  assign access  = proc_read | proc_write;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
      assign hit_vec[gi] = valid_reg[set_idx][gi] && (tag_reg[set_idx][gi] == tag);
    end
  endgenerate

  assign hit = |hit_vec;

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  assign hit_block  = data_reg[set_idx][hit_way];
  assign proc_rdata = hit ? hit_block[{off, 5'b0} +: 32] : 32'h0;

  // Flush pointer walks lines set-major, way-minor.
  assign flush_set   = SET_W'(flush_ptr_reg >> $clog2(WAYS));
  assign flush_way   = WAY_W'(flush_ptr_reg & LINE_W'(WAYS - 1));
  assign flush_dirty = valid_reg[flush_set][flush_way] && dirty_reg[flush_set][flush_way];
  assign flush_last  = (flush_ptr_reg == LINE_W'(LINES - 1));

  assign lru_touch = ((state_reg == READY) && access && hit) || ((state_reg == ALLOC) && mem_ready);
  assign lru_way   = (state_reg == ALLOC) ? victim_reg : hit_way;

  cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk       (clk),
    .srst      (proc_reset),
    .touch     (lru_touch),
    .set_idx   (set_idx),
    .touch_way (lru_way),
    .valid_vec (valid_reg[set_idx]),
    .victim    (lru_victim)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      READY: begin
        if (access && !hit)
          state_next = (valid_reg[set_idx][lru_victim] && dirty_reg[set_idx][lru_victim]) ? WBACK : ALLOC;
        else if (proc_flush && !access && !flush_done_reg)
          state_next = FL_SCAN;
      end
      WBACK:   if (mem_ready) state_next = ALLOC;
      ALLOC:   if (mem_ready) state_next = READY;
      FL_SCAN: begin
        if (flush_dirty)     state_next = FL_WB;
        else if (flush_last) state_next = READY;
      end
      FL_WB:   if (mem_ready) state_next = FL_SCAN;
      default: state_next = READY;
    endcase
  end

  assign mem_read        = (state_reg == ALLOC) && !mem_ready;
  assign mem_write       = ((state_reg == WBACK) || (state_reg == FL_WB)) && !mem_ready;
  assign proc_flush_done = flush_done_reg;
  // A held flush request stays stalled until its done pulse is visible.
  assign proc_stall      = (access && !hit) || (state_reg != READY) || (proc_flush && !flush_done_reg);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      WBACK: begin
        mem_addr  = {tag_reg[set_idx][victim_reg], set_idx};
        mem_wdata = data_reg[set_idx][victim_reg];
      end
      FL_WB: begin
        mem_addr  = {tag_reg[flush_set][flush_way], flush_set};
        mem_wdata = data_reg[flush_set][flush_way];
      end
      ALLOC:   mem_addr = {tag, set_idx};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_reg      <= READY;
      victim_reg     <= '0;
      flush_ptr_reg  <= '0;
      flush_done_reg <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          data_reg[s][w] <= '0;
          tag_reg[s][w]  <= '0;
        end
      end
    end else begin
      state_reg      <= state_next;
      flush_done_reg <= 1'b0;
      case (state_reg)
        READY: begin
          if (access && hit && proc_write) begin
            data_reg[set_idx][hit_way][{off, 5'b0} +: 32] <= proc_wdata;
            dirty_reg[set_idx][hit_way]                   <= 1'b1;
          end
          // Victim is frozen for the whole miss so WBACK and ALLOC agree.
          if (access && !hit) victim_reg <= lru_victim;
        end
        ALLOC: begin
          if (mem_ready) begin
            data_reg[set_idx][victim_reg]  <= mem_rdata;
            tag_reg[set_idx][victim_reg]   <= tag;
            valid_reg[set_idx][victim_reg] <= 1'b1;
            dirty_reg[set_idx][victim_reg] <= 1'b0;
          end
        end
        FL_SCAN: begin
          if (!flush_dirty) begin
            if (flush_last) begin
              flush_ptr_reg  <= '0;
              flush_done_reg <= 1'b1;
            end else begin
              flush_ptr_reg <= flush_ptr_reg + 1'b1;
            end
          end
        end
        FL_WB: if (mem_ready) dirty_reg[flush_set][flush_way] <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_assoc.sv
// Self-checking bench for cache_assoc: recency-list cache model plus shadow memory,
// directed scenarios and randomized accesses/flushes with a random-latency memory.
module tb_cache_assoc;

  localparam int ADDR_W  = 30;
  localparam int SETS    = 4;
  localparam int WAYS    = 4;
  localparam int WORDS   = 4;
  localparam int OFF_W   = 2;
  localparam int SET_W   = 2;
  localparam int BLK_W   = 32 * WORDS;
  localparam int BADDR_W = ADDR_W - OFF_W;

  logic               clk;
  logic               proc_reset, proc_read, proc_write, proc_flush;
  logic [ADDR_W-1:0]  proc_addr;
  logic [31:0]        proc_wdata, proc_rdata;
  logic               proc_stall, proc_flush_done;
  logic               mem_read, mem_write, mem_ready;
  logic [BADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]   mem_wdata, mem_rdata;

  cache_assoc #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_flush(proc_flush), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall), .proc_flush_done(proc_flush_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  task automatic abort_run(input string name);
    errors++;
    checks++;
    $display("FAIL %s: bound expired", name);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "run stopped: %s", name);
  endtask

  // ---------------- behavioural model ----------------
  logic             m_valid [SETS][WAYS];
  logic             m_dirty [SETS][WAYS];
  int unsigned      m_tag   [SETS][WAYS];
  logic [BLK_W-1:0] m_data  [SETS][WAYS];
  int               order   [SETS][WAYS];  // recency list, [0] = most recent
  logic [BLK_W-1:0] mem_model [int unsigned];
  logic [BLK_W-1:0] backing   [int unsigned];

  bit               exp_wr[$];
  int unsigned      exp_addr[$];
  logic [BLK_W-1:0] exp_data[$];
  bit               obs_wr[$];
  int unsigned      obs_addr[$];
  logic [BLK_W-1:0] obs_data[$];

  function automatic logic [BLK_W-1:0] init_block(input int unsigned b);
    logic [BLK_W-1:0] blk;
    for (int w = 0; w < WORDS; w++) blk[32*w +: 32] = {b[15:0], 16'(w)};
    return blk;
  endfunction

  function automatic logic [BLK_W-1:0] model_mem_get(input int unsigned b);
    return mem_model.exists(b) ? mem_model[b] : init_block(b);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = 0;
        m_data[s][w]  = '0;
        order[s][w]   = w;
      end
  endfunction

  function automatic void model_touch(input int s, input int w);
    int pos = 0;
    for (int i = 0; i < WAYS; i++) if (order[s][i] == w) pos = i;
    for (int i = pos; i > 0; i--) order[s][i] = order[s][i-1];
    order[s][0] = w;
  endfunction

  function automatic int model_victim(input int s);
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    return order[s][WAYS-1];
  endfunction

  function automatic void model_access(input bit wr, input int unsigned addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output bit was_hit);
    int s   = int'((addr >> OFF_W) % SETS);
    int unsigned t = addr >> (OFF_W + SET_W);
    int o   = int'(addr % WORDS);
    int way = -1;
    exp_wr.delete(); exp_addr.delete(); exp_data.delete();
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    was_hit = (way >= 0);
    if (!was_hit) begin
      way = model_victim(s);
      if (m_valid[s][way] && m_dirty[s][way]) begin
        exp_wr.push_back(1'b1);
        exp_addr.push_back((m_tag[s][way] << SET_W) | s);
        exp_data.push_back(m_data[s][way]);
        mem_model[(m_tag[s][way] << SET_W) | s] = m_data[s][way];
      end
      exp_wr.push_back(1'b0);
      exp_addr.push_back((t << SET_W) | s);
      exp_data.push_back('0);
      m_data[s][way]  = model_mem_get((t << SET_W) | s);
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = 1'b0;
      m_tag[s][way]   = t;
    end
    rd = m_data[s][way][32*o +: 32];
    model_touch(s, way);
    if (wr) begin
      m_data[s][way][32*o +: 32] = wdata;
      m_dirty[s][way] = 1'b1;
    end
  endfunction

  function automatic void model_flush();
    exp_wr.delete(); exp_addr.delete(); exp_data.delete();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          exp_wr.push_back(1'b1);
          exp_addr.push_back((m_tag[s][w] << SET_W) | s);
          exp_data.push_back(m_data[s][w]);
          mem_model[(m_tag[s][w] << SET_W) | s] = m_data[s][w];
          m_dirty[s][w] = 1'b0;
        end
  endfunction

  function automatic void compare_xfers(input string ctx);
    check({ctx, "_xfer_count"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
      check({ctx, "_xfer_kind"}, obs_wr[i], exp_wr[i]);
      check({ctx, "_xfer_addr"}, obs_addr[i], exp_addr[i]);
      check({ctx, "_xfer_data"}, obs_data[i], exp_data[i]);
    end
  endfunction

  // ---------------- memory responder ----------------
  bit mem_hold = 1'b0;
  int delay_cnt = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (!mem_hold && !proc_reset && (mem_read || mem_write)) begin
        if (delay_cnt > 0) begin
          delay_cnt--;
        end else begin
          obs_wr.push_back(mem_write);
          obs_addr.push_back(32'(mem_addr));
          obs_data.push_back(mem_write ? mem_wdata : '0);
          if (mem_write) backing[32'(mem_addr)] = mem_wdata;
          else mem_rdata = backing.exists(32'(mem_addr)) ? backing[32'(mem_addr)] : init_block(32'(mem_addr));
          mem_ready = 1'b1;
          delay_cnt = $urandom_range(0, 3);
        end
      end
    end
  end

  // Every cycle: the two transfer requests must never overlap.
  always @(negedge clk) begin
    #3;
    if (!proc_reset) check("mem_rw_exclusive", mem_read && mem_write, 1'b0);
  end

  // ---------------- driver tasks ----------------
  logic [31:0] last_rdata;

  task automatic do_access(input bit rd, input bit wr, input int unsigned addr, input logic [31:0] wdata);
    logic [31:0] exp_rd;
    bit exp_hit;
    int cyc = 0;
    model_access(wr, addr, wdata, exp_rd, exp_hit);
    obs_wr.delete(); obs_addr.delete(); obs_data.delete();
    @(negedge clk);
    proc_read = rd; proc_write = wr; proc_addr = ADDR_W'(addr); proc_wdata = wdata;
    #1;
    while (proc_stall) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc > 200) abort_run("access_timeout");
    end
    check("rdata", proc_rdata, exp_rd);
    check("hit_without_stall", cyc == 0, exp_hit);
    last_rdata = proc_rdata;
    @(posedge clk);
    #1;
    proc_read = 1'b0; proc_write = 1'b0;
    compare_xfers("access");
  endtask

  task automatic do_flush();
    int cyc = 0;
    model_flush();
    obs_wr.delete(); obs_addr.delete(); obs_data.delete();
    @(negedge clk);
    proc_flush = 1'b1;
    #1;
    while (!proc_flush_done) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc > 500) abort_run("flush_timeout");
    end
    check("flush_done_stall", proc_stall, 1'b0);
    proc_flush = 1'b0;
    @(negedge clk);
    #1;
    check("flush_done_one_cycle", proc_flush_done, 1'b0);
    compare_xfers("flush");
  endtask

  task automatic reset_dut();
    @(negedge clk);
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0;
    model_reset();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int unsigned a;
    logic [BLK_W-1:0] blk;
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_flush = 1'b0;
    proc_addr = '0; proc_wdata = '0;
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
    model_reset();
    #1;
    check("rst_stall", proc_stall, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_flush_done", proc_flush_done, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_rdata", proc_rdata, '0);

    // Cold read miss, then hit on the next word of the same block.
    do_access(1'b1, 1'b0, 32'h10, 32'h0);
    check("cold_fill_addr", obs_addr.size() > 0 ? obs_addr[0] : 32'hFFFF_FFFF, 32'h4);
    check("cold_rdata_word0", last_rdata, 32'h0004_0000);
    do_access(1'b1, 1'b0, 32'h11, 32'h0);
    check("hit_rdata_word1", last_rdata, 32'h0004_0001);
    check("hit_no_traffic", obs_wr.size(), 0);

    // Dirty line evicted after four more tags in set 0.
    do_access(1'b0, 1'b1, 32'h11, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h20, 32'h0);
    do_access(1'b1, 1'b0, 32'h30, 32'h0);
    do_access(1'b1, 1'b0, 32'h40, 32'h0);
    do_access(1'b1, 1'b0, 32'h50, 32'h0);
    check("evict_is_write", obs_wr.size() > 0 ? obs_wr[0] : 1'b0, 1'b1);
    check("evict_addr", obs_addr.size() > 0 ? obs_addr[0] : 32'hFFFF_FFFF, 32'h4);
    blk = obs_data.size() > 0 ? obs_data[0] : '0;
    check("evict_word1", blk[63:32], 32'hDEADBEEF);

    // LRU victim choice in set 1.
    reset_dut();
    do_access(1'b1, 1'b0, 32'hA4, 32'h0);
    do_access(1'b1, 1'b0, 32'hB4, 32'h0);
    do_access(1'b1, 1'b0, 32'hC4, 32'h0);
    do_access(1'b1, 1'b0, 32'hD4, 32'h0);
    do_access(1'b1, 1'b0, 32'hA4, 32'h0);
    do_access(1'b1, 1'b0, 32'hE4, 32'h0);
    check("lru_fill_count", obs_wr.size(), 1);
    check("lru_fill_addr", obs_addr.size() > 0 ? obs_addr[0] : 32'hFFFF_FFFF, 32'h39);
    do_access(1'b1, 1'b0, 32'hA4, 32'h0);
    check("lru_a_kept", obs_wr.size(), 0);
    do_access(1'b1, 1'b0, 32'hB4, 32'h0);
    check("lru_b_evicted", obs_addr.size() > 0 ? obs_addr[0] : 32'hFFFF_FFFF, 32'h2D);

    // Flush with dirty lines in sets 0 and 3.
    reset_dut();
    do_access(1'b0, 1'b1, 32'h00, 32'h1111_1111);
    do_access(1'b0, 1'b1, 32'h0E, 32'h3333_3333);
    do_flush();
    check("flush_write_count", obs_wr.size(), 2);
    check("flush_first_addr", obs_addr.size() > 0 ? obs_addr[0] : 32'hFFFF_FFFF, 32'h0);
    check("flush_second_addr", obs_addr.size() > 1 ? obs_addr[1] : 32'hFFFF_FFFF, 32'h3);
    do_access(1'b1, 1'b0, 32'h00, 32'h0);
    check("post_flush_hit_rdata", last_rdata, 32'h1111_1111);
    check("post_flush_no_read", obs_wr.size(), 0);

    // Reset while a fill is outstanding.
    mem_hold = 1'b1;
    @(negedge clk);
    proc_read = 1'b1; proc_addr = ADDR_W'(32'h100);
    cyc = 0;
    #1;
    while (!mem_read && cyc < 10) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("alloc_reached", mem_read, 1'b1);
    proc_reset = 1'b1; proc_read = 1'b0;
    @(negedge clk);
    #1;
    check("reset_drops_mem_read", mem_read, 1'b0);
    check("reset_drops_mem_write", mem_write, 1'b0);
    proc_reset = 1'b0;
    mem_hold = 1'b0;
    model_reset();
    do_access(1'b1, 1'b0, 32'h100, 32'h0);
    check("post_reset_miss", obs_wr.size(), 1);

    // Randomized traffic over a small tag pool so evictions and hits both occur.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
      end else begin
        a = ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        case ($urandom_range(0, 2))
          0:       do_access(1'b1, 1'b0, a, $urandom);
          1:       do_access(1'b0, 1'b1, a, $urandom);
          default: do_access(1'b1, 1'b1, a, $urandom);
        endcase
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
